// File: rtl/overture_exec_ctrl.sv
// overture_exec_ctrl: single-cycle OVERTURE execute controller with register file, ALU hookup, byte I/O and conditional jumps
module overture_exec_ctrl #(
   parameter logic [7:0] RESET_PC = 8'd0,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic [7:0]       pc,
   input  logic [7:0]       instr,
   output logic [7:0]       alu_op,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   input  logic [7:0]       alu_result,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] retired
);
   logic [5:0][7:0] regs;
   logic [1:0] mode;
   logic [2:0] src, dst;
   logic [7:0] src_val, pc_inc;
   logic act, src6, dst6, stall, exec, zero, neg, base, taken;

   assign mode    = instr[7:6];
   assign src     = instr[5:3];
   assign dst     = instr[2:0];
   assign pc_inc  = pc + 8'd1;
   assign alu_op  = instr;
   assign alu_a   = regs[1];
   assign alu_b   = regs[2];
   // I/O handshakes only exist for a COPY while out of reset and running
   assign act     = rst & run & (mode == 2'b10);
   assign src6    = act & (src == 3'd6);
   assign dst6    = act & (dst == 3'd6);
   assign src_val = (src < 3'd6) ? regs[src] : (src == 3'd6) ? in_data : 8'h00;
   assign in_ready  = src6 & ((dst != 3'd6) | out_ready);
   assign out_valid = dst6 & ((src != 3'd6) | in_valid);
   assign out_data  = src_val;
   assign stall   = (src6 & ~(in_valid & in_ready)) | (dst6 & ~(out_valid & out_ready));
   assign exec    = run & ~stall;
   // conditions 4..7 are the complements of 0..3, so bit 2 inverts the base test
   assign zero    = (regs[3] == 8'h00);
   assign neg     = regs[3][7];
   assign base    = instr[1] ? (instr[0] ? (neg | zero) : neg) : (instr[0] & zero);
   assign taken   = instr[2] ^ base;

   // architectural state update, one instruction per executing edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc      <= RESET_PC;
         regs    <= '0;
         retired <= '0;
      end else if (exec) begin
         retired <= retired + 1'b1;
         pc      <= (mode == 2'b11 && taken) ? regs[0] : pc_inc;
         if (mode == 2'b00) regs[0] <= {2'b00, instr[5:0]};
         else if (mode == 2'b01) regs[3] <= alu_result;
         else if (mode == 2'b10 && dst < 3'd6) regs[dst] <= src_val;
      end
   end
endmodule

// File: tb/tb_overture_exec_ctrl.sv
// tb_overture_exec_ctrl: scoreboard bench for the OVERTURE execute controller
module tb_overture_exec_ctrl;
   logic clk = 1'b0;
   logic rst, run, in_valid, in_ready, out_valid, out_ready;
   logic [7:0] pc, instr, alu_op, alu_a, alu_b, alu_result, in_data, out_data;
   logic [15:0] retired;

   typedef struct {string name; int sel; logic [15:0] val;} chk_t;
   chk_t sq[$];
   logic [7:0] oq[$];
   int n_chk = 0, n_err = 0;
   logic [7:0] ep;
   logic [15:0] er;

   overture_exec_ctrl #(.RESET_PC(8'd0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .run(run), .pc(pc), .instr(instr),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .retired(retired)
   );

   always #5 clk = ~clk;

   // reference ALU: op4 add, op5 subtract
   always_comb
      alu_result = (alu_op[2:0] == 3'd4) ? alu_a + alu_b : (alu_op[2:0] == 3'd5) ? alu_a - alu_b : 8'h00;

   function automatic logic [15:0] obs(input int sel);
      case (sel)
         0: obs = {8'h00, pc};
         1: obs = retired;
         2: obs = {8'h00, alu_a};
         3: obs = {8'h00, alu_b};
         4: obs = {15'h0, in_ready};
         5: obs = {15'h0, out_valid};
         6: obs = {8'h00, out_data};
         default: obs = {8'h00, alu_op};
      endcase
   endfunction

   // monitor: state checks at mid-cycle, output-port transfers on handshake
   always @(negedge clk) begin
      chk_t c;
      logic [7:0] e;
      while (sq.size() > 0) begin
         c = sq.pop_front();
         n_chk++;
         if (obs(c.sel) !== c.val) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", c.name, obs(c.sel), c.val, $time);
         end
      end
      if (rst && out_valid && out_ready) begin
         n_chk++;
         if (oq.size() == 0) begin
            n_err++;
            $display("FAIL out_xfer: got unexpected byte %h expected none at %0t", out_data, $time);
         end else begin
            e = oq.pop_front();
            if (out_data !== e) begin
               n_err++;
               $display("FAIL out_xfer: got %h expected %h at %0t", out_data, e, $time);
            end
         end
      end
   end

   task automatic exp(input string name, input int sel, input logic [15:0] val);
      sq.push_back('{name, sel, val});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [7:0] i, input logic [7:0] next_pc);
      instr = i;
      exp("pc", 0, {8'h00, ep});
      exp("retired", 1, er);
      tick();
      ep = next_pc;
      er = er + 16'd1;
   endtask

   task automatic go(input logic [7:0] i);
      step(i, ep + 8'd1);
   endtask

   initial begin
      rst = 1'b1; run = 1'b1; instr = 8'hB6; in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
      ep = 8'h00; er = 16'h0;
      #1 rst = 1'b0;
      #1;
      exp("rst_pc", 0, 16'h0);
      exp("rst_retired", 1, 16'h0);
      exp("rst_in_ready", 4, 16'h0);
      exp("rst_out_valid", 5, 16'h0);
      tick();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      step(8'h05, 8'h01);
      out_ready = 1'b1;
      oq.push_back(8'h05);
      go(8'h86);
      go(8'h0C); go(8'h81); go(8'h0A); go(8'h82);
      exp("alu_a", 2, 16'h000C);
      exp("alu_b", 3, 16'h000A);
      exp("alu_op", 7, 16'h0044);
      go(8'h44);
      oq.push_back(8'h16);
      go(8'h9E);
      go(8'h45);
      oq.push_back(8'h02);
      go(8'h9E);
      out_ready = 1'b0; in_valid = 1'b0; instr = 8'hB0;
      repeat (3) begin
         exp("in_stall_pc", 0, {8'h00, ep});
         exp("in_stall_retired", 1, er);
         exp("in_stall_ready", 4, 16'h1);
         tick();
      end
      in_valid = 1'b1; in_data = 8'h7E;
      exp("in_ready", 4, 16'h1);
      go(8'hB0);
      in_valid = 1'b0;
      step(8'hC4, 8'h7E);
      go(8'h22); go(8'h83);
      out_ready = 1'b0; instr = 8'h9E;
      repeat (4) begin
         exp("out_stall_pc", 0, {8'h00, ep});
         exp("out_stall_retired", 1, er);
         exp("out_stall_valid", 5, 16'h1);
         exp("out_stall_data", 6, 16'h0022);
         tick();
      end
      out_ready = 1'b1;
      oq.push_back(8'h22);
      go(8'h9E);
      out_ready = 1'b0;
      go(8'h00); go(8'h81); go(8'h01); go(8'h82); go(8'h45); go(8'h9C);
      go(8'h20); go(8'h81); go(8'h82); go(8'h44); go(8'h98); go(8'hA3);
      step(8'hC2, 8'h40);
      step(8'hC7, 8'h41);
      step(8'hC0, 8'h42);
      step(8'hC5, 8'h40);
      go(8'h98);
      step(8'hC4, 8'hFF);
      step(8'hC1, 8'h00);
      in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
      oq.push_back(8'h5A);
      exp("pass_in_ready", 4, 16'h1);
      exp("pass_out_valid", 5, 16'h1);
      exp("pass_out_data", 6, 16'h005A);
      go(8'hB6);
      in_valid = 1'b0;
      exp("pass_hold_valid", 5, 16'h0);
      exp("pass_hold_pc", 0, {8'h00, ep});
      tick();
      run = 1'b0; instr = 8'h9E;
      exp("norun_valid", 5, 16'h0);
      exp("norun_pc", 0, {8'h00, ep});
      tick();
      run = 1'b1; out_ready = 1'b0;
      exp("norun_held_pc", 0, {8'h00, ep});
      exp("norun_held_retired", 1, er);
      exp("stall_valid", 5, 16'h1);
      tick();
      rst = 1'b0;
      #1;
      exp("rst_stall_valid", 5, 16'h0);
      exp("rst_stall_pc", 0, 16'h0);
      exp("rst_stall_retired", 1, 16'h0);
      tick();
      rst = 1'b1;
      #20;
      n_chk++;
      if (oq.size() != 0) begin
         n_err++;
         $display("FAIL out_queue: got %0d pending bytes expected 0", oq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
